// File: rtl/mips_trace_monitor.sv
// rtl/mips_trace_monitor.sv - MIPS execution trace monitor with circular trace buffer, halt detect and watchdog.
// Optional feature macro: MIPS_TRACE_PRINT_EN (per-sample and verdict $display; off by default).
module mips_trace_monitor #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 16,
   parameter int MAX_CYCLES = 1000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_valid,
   input  logic [ADDR_W-1:0]          pc,
   input  logic [31:0]                instruction,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic                       zero,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       rd_valid,
   output logic [ADDR_W-1:0]          rd_pc,
   output logic [31:0]                rd_instr,
   output logic [DATA_W-1:0]          rd_alu,
   output logic                       rd_zero,
   output logic [$clog2(DEPTH):0]     entries,
   output logic                       overflow,
   output logic [31:0]                retired,
   output logic                       halted,
   output logic                       timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;

   state_t            state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_base;
   logic [CW-1:0]     cyc_cnt;
   logic [ADDR_W-1:0] last_pc;

   logic [ADDR_W-1:0] mem_pc    [DEPTH];
   logic [31:0]       mem_instr [DEPTH];
   logic [DATA_W-1:0] mem_alu   [DEPTH];
   logic              mem_zero  [DEPTH];

   logic          accept;
   logic          hit;
   logic          full;
   logic          in_range;
   logic [AW-1:0] phys;
   logic [31:0]   retired_nxt;

   always_comb begin
      accept      = sample_valid && (state == IDLE || state == RUN);
      // only RUN can halt, so the very first sample after reset never does
      hit         = accept && (state == RUN) && (pc == last_pc);
      full        = (entries == (AW+1)'(DEPTH));
      in_range    = ({1'b0, rd_idx} < entries);
      phys        = rd_base + rd_idx;
      retired_nxt = retired;
      if (accept && retired != 32'hFFFF_FFFF)
         retired_nxt = retired + 32'd1;
   end

   // Storage has no reset; entries/rd_base decide what is visible.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= instruction;
         mem_alu[wr_ptr]   <= alu_result;
         mem_zero[wr_ptr]  <= zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_base  <= '0;
         cyc_cnt  <= '0;
         last_pc  <= '0;
         entries  <= '0;
         overflow <= 1'b0;
         retired  <= '0;
         rd_valid <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
         rd_alu   <= '0;
         rd_zero  <= 1'b0;
      end else begin
         if (rd_en) begin
            rd_valid <= in_range;
            rd_pc    <= in_range ? mem_pc[phys]    : '0;
            rd_instr <= in_range ? mem_instr[phys] : '0;
            rd_alu   <= in_range ? mem_alu[phys]   : '0;
            rd_zero  <= in_range ? mem_zero[phys]  : 1'b0;
         end

         if (accept) begin
            wr_ptr  <= wr_ptr + 1'b1;
            last_pc <= pc;
            retired <= retired_nxt;
            if (full) begin
               rd_base  <= rd_base + 1'b1;
               overflow <= 1'b1;
            end else begin
               entries  <= entries + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               cyc_cnt <= '0;
               if (accept)
                  state <= RUN;
            end
            RUN: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               // a halt on the expiry cycle takes precedence over the watchdog
               if (hit)
                  state <= HALTED;
               else if (cyc_cnt == CW'(MAX_CYCLES - 1))
                  state <= TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   assign halted  = (state == HALTED);
   assign timeout = (state == TIMEOUT);

`ifdef MIPS_TRACE_PRINT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept)
            $display("%0t pc=%h instr=%h alu=%h zero=%h", $time, pc, instruction, alu_result, zero);
         if (hit)
            $display("HALT pc=%h retired=%0d", pc, retired_nxt);
         else if (state == RUN && cyc_cnt == CW'(MAX_CYCLES - 1))
            $display("TIMEOUT retired=%0d", retired_nxt);
      end
   end
`endif

endmodule

// File: tb/tb_mips_trace_monitor.sv
// tb/tb_mips_trace_monitor.sv - scoreboard bench for mips_trace_monitor against a queue-based trace model.
module tb_mips_trace_monitor;

   localparam int DEPTH = 16;
   localparam int MAXC  = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_valid = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instruction = '0;
   logic [31:0] alu_result = '0;
   logic        zero = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic [31:0] rd_alu;
   logic        rd_zero;
   logic [4:0]  entries;
   logic        overflow;
   logic [31:0] retired;
   logic        halted;
   logic        timeout;

   mips_trace_monitor #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .pc(pc),
      .instruction(instruction), .alu_result(alu_result), .zero(zero),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
      .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_zero(rd_zero),
      .entries(entries), .overflow(overflow), .retired(retired),
      .halted(halted), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] alu;
      logic        z;
   } ent_t;

   typedef struct packed {
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] rins;
      logic [31:0] ralu;
      logic        rz;
      logic [4:0]  ent;
      logic        ovf;
      logic [31:0] ret;
      logic        hlt;
      logic        tmo;
   } exp_t;

   // Model: trace is a plain list of held samples, oldest first.
   ent_t        mq[$];
   exp_t        expq[$];
   exp_t        cur = '0;
   int          mode = 0;       // 0 idle, 1 run, 2 halted, 3 timeout
   int          run_edges = 0;
   logic [31:0] mlast = '0;
   logic [31:0] mret = '0;
   bit          movf = 0;

   int errors = 0;
   int checks = 0;

   task automatic step(input bit r, input bit sv, input logic [31:0] p,
                       input bit re, input logic [3:0] idx);
      logic [31:0] ins, alu;
      bit          z, acc, hit;
      ent_t        e;
      @(negedge clk);
      ins = $urandom;
      alu = $urandom;
      z   = 1'($urandom_range(0, 1));
      rst = r; sample_valid = sv; pc = p; instruction = ins;
      alu_result = alu; zero = z; rd_en = re; rd_idx = idx;
      if (r) begin
         mq.delete();
         mode = 0; run_edges = 0; mret = '0; movf = 0; mlast = '0; cur = '0;
      end else begin
         if (re) begin
            if (int'(idx) < mq.size()) begin
               cur.rv = 1'b1; cur.rpc = mq[idx].pc; cur.rins = mq[idx].ins;
               cur.ralu = mq[idx].alu; cur.rz = mq[idx].z;
            end else begin
               cur.rv = 1'b0; cur.rpc = '0; cur.rins = '0; cur.ralu = '0; cur.rz = 1'b0;
            end
         end
         acc = sv && (mode < 2);
         hit = 0;
         if (acc) begin
            e = '{p, ins, alu, z};
            mq.push_back(e);
            if (mq.size() > DEPTH) begin
               void'(mq.pop_front());
               movf = 1;
            end
            if (mret != 32'hFFFF_FFFF) mret++;
            hit = (mode == 1) && (p == mlast);
            mlast = p;
         end
         if (mode == 0 && acc) begin
            mode = 1;
            run_edges = 0;
         end else if (mode == 1) begin
            run_edges++;
            if (hit) mode = 2;
            else if (run_edges == MAXC) mode = 3;
         end
      end
      cur.ent = 5'(mq.size());
      cur.ovf = movf;
      cur.ret = mret;
      cur.hlt = (mode == 2);
      cur.tmo = (mode == 3);
      expq.push_back(cur);
   endtask

   task automatic samp(input logic [31:0] p); step(0, 1, p, 0, 4'd0); endtask
   task automatic rd(input logic [3:0] i);    step(0, 0, '0, 1, i);   endtask
   task automatic idle();                     step(0, 0, '0, 0, 4'd0); endtask
   task automatic do_reset();                 step(1, 0, '0, 0, 4'd0); endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if ({rd_valid, rd_pc, rd_instr, rd_alu, rd_zero} !== {e.rv, e.rpc, e.rins, e.ralu, e.rz}) begin
               errors++;
               $display("FAIL read t=%0t got v=%0d pc=%h ins=%h alu=%h z=%0d want v=%0d pc=%h ins=%h alu=%h z=%0d",
                        $time, rd_valid, rd_pc, rd_instr, rd_alu, rd_zero, e.rv, e.rpc, e.rins, e.ralu, e.rz);
            end
            checks++;
            if ({entries, overflow, retired, halted, timeout} !== {e.ent, e.ovf, e.ret, e.hlt, e.tmo}) begin
               errors++;
               $display("FAIL status t=%0t got ent=%0d ovf=%0d ret=%0d hlt=%0d tmo=%0d want ent=%0d ovf=%0d ret=%0d hlt=%0d tmo=%0d",
                        $time, entries, overflow, retired, halted, timeout, e.ent, e.ovf, e.ret, e.hlt, e.tmo);
            end
         end
      end
   end

   initial begin : guard
      #2000000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench time limit");
   end

   initial begin : stimulus
      do_reset();
      for (int i = 0; i < 5; i++) samp(32'(4 * i));
      rd(4'd2);
      idle();

      do_reset();
      samp(32'h0); samp(32'h4); samp(32'h8);
      rd(4'd3);
      samp(32'hC);
      do_reset();
      idle();
      samp(32'h100); samp(32'h104);
      rd(4'd0);

      do_reset();
      for (int i = 0; i < 20; i++) samp(32'(4 * i));
      rd(4'd0);
      rd(4'd15);
      idle();

      do_reset();
      samp(32'h0); samp(32'h4); samp(32'h4);
      samp(32'h8); samp(32'hC);
      rd(4'd2);
      rd(4'd3);

      do_reset();
      for (int i = 0; i < 56; i++) samp(32'(4 * i));
      rd(4'd15);
      idle();

      do_reset();
      for (int i = 0; i < 50; i++) samp(32'(4 * i));
      samp(32'(4 * 49));
      samp(32'h1000);
      idle();

      for (int k = 0; k < 6; k++) begin
         do_reset();
         for (int n = 0; n < 300; n++) begin
            logic [31:0] p;
            p = (k % 2 == 1) ? {26'd0, 4'($urandom_range(0, 15)), 2'b00} : 32'(4 * n);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, p,
                 $urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)));
         end
      end

      idle();
      idle();
      @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_trace_monitor.md
# mips_trace_monitor

Parametrised, synthesizable execution-trace monitor for the MIPS core. It samples the per-cycle PC, instruction, ALU result and zero flag into a circular trace buffer. It also counts retired instructions, detects a branch-to-self halt and enforces a cycle-budget watchdog. It sits beside `mips` in the testbench and replaces free-running `$monitor` printing with a bounded, readable trace and a pass/timeout verdict.

## Interface
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: ALU result width.
- `DEPTH`, 16: trace buffer entries; power of two, ≥2.
- `MAX_CYCLES`, 1000: watchdog budget in clock cycles, counted from the first sample.
- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sample_valid`  in  1  current cycle's fields are a retired instruction.
- `pc`  in  ADDR_W  PC of the sampled instruction.
- `instruction`  in  32  instruction word.
- `alu_result`  in  DATA_W  ALU output.
- `zero`  in  1  ALU zero flag.
- `rd_en`  in  1  trace read request.
- `rd_idx`  in  $clog2(DEPTH)  entry index; 0 is the oldest held entry.
- `rd_valid`  out  1  read data valid; `rd_idx` < `entries` at request.
- `rd_pc` / `rd_instr` / `rd_alu` / `rd_zero`  out  ADDR_W / 32 / DATA_W / 1  read entry fields.
- `entries`  out  $clog2(DEPTH)+1  held entries, 0..DEPTH.
- `overflow`  out  1  sticky; an entry was overwritten.
- `retired`  out  32  accepted sample count; saturates at 32'hFFFF_FFFF.
- `halted`  out  1  state == HALTED.
- `timeout`  out  1  state == TIMEOUT.

## Operation
- States:
  - IDLE: after reset.
  - RUN: entered on the first accepted sample.
  - HALTED: terminal.
  - TIMEOUT: terminal.
- Accept: `sample_valid` in IDLE or RUN. In HALTED or TIMEOUT, samples are ignored and nothing changes.
- Accepted sample:
  - Write {pc, instruction, alu_result, zero} at `wr_ptr`; `wr_ptr` wraps mod DEPTH.
  - `entries` increments to DEPTH and holds there.
  - When `entries` == DEPTH, the oldest entry is overwritten, the oldest pointer advances and `overflow` sets.
  - `retired` increments.
- Halt: an accepted sample whose `pc` equals the previous accepted sample's `pc` (branch-to-self) is recorded, then RUN→HALTED. The first sample after reset never halts.
- Watchdog: `cyc_cnt` clears in IDLE and increments every cycle in RUN. When `cyc_cnt` == MAX_CYCLES−1 with no halt that cycle, RUN→TIMEOUT.
- Simultaneous halt and watchdog expiry: HALTED wins. The sample is recorded.
- Read:
  - Physical address = (oldest + `rd_idx`) mod DEPTH.
  - If `rd_idx` ≥ `entries`: `rd_valid`=0 and data = 0.
  - A read and a write in the same cycle return pre-write contents.
- `rst` at any time, including mid-run or in a terminal state: returns to IDLE and clears the buffer pointers, counters and flags in the next cycle.

## Timing
- Reset values:
  - `rd_valid`=0; `rd_pc`/`rd_instr`/`rd_alu`/`rd_zero`=0.
  - `entries`=0; `overflow`=0; `retired`=0; `halted`=0; `timeout`=0.
- Sample at edge N: `entries`, `retired` and `overflow` update after edge N. The entry is readable by a request at edge N+1.
- Read: `rd_en` sampled at edge N, data and `rd_valid` registered after edge N (1-cycle latency). Outputs hold until the next `rd_en`.
- `halted`/`timeout` assert after the edge of the triggering sample/cycle and hold until `rst`.
- No backpressure: the monitor never stalls the core.

## Configuration
- `MIPS_TRACE_PRINT_EN` defined:
  - Each accepted sample also issues `$display` of time, PC, instruction, ALU result and zero, all hex.
  - Entry to HALTED prints "HALT pc=<hex> retired=<dec>".
  - Entry to TIMEOUT prints "TIMEOUT retired=<dec>".
- Undefined: no display statements are compiled and the block is fully synthesizable. Functional behaviour is identical in both cases.

## Test plan
- Reset, then 5 samples, pc=0x00,0x04,…,0x10 → `entries`=5, `retired`=5, `overflow`=0; `rd_idx`=2 returns pc=0x08 one cycle after `rd_en`.
- DEPTH=16, 20 distinct samples → `entries`=16, `overflow`=1, `rd_idx`=0 returns the 5th sample (pc=0x10), `rd_idx`=15 returns pc=0x4C.
- Samples pc=0x00,0x04,0x04 → `halted`=1 after the third; `retired`=3; further samples do not change `retired` or `entries`.
- MAX_CYCLES=50, distinct PCs every cycle → `timeout`=1 after cycle 50. With the halt sample on cycle 50, `halted`=1 and `timeout`=0.
- With `entries`=3, read `rd_idx`=3 → `rd_valid`=0, data=0. Then assert `rst` mid-run → all outputs 0 next cycle and a fresh run restarts in IDLE.
